// File: rtl/clk_monitor_pkg.sv
// Shared types for the clock pulse monitor.
// Holds the phase-tracking FSM state encoding.
package clk_monitor_pkg;

    typedef enum logic [1:0] {
        SYNCING = 2'd0,
        HIGH    = 2'd1,
        LOW     = 2'd2
    } mon_state_e;

endpackage

// File: rtl/clk_pulse_monitor_sync.sv
// Multi-flop synchronizer bringing an asynchronous level into clk_i.
// Flops reset to 0 so a held-high input looks like a fresh rise.
module sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic serial_i,
    output logic serial_o
);

    logic [STAGES-1:0] reg_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            reg_q <= '0;
        end else begin
            reg_q <= {reg_q[STAGES-2:0], serial_i};
        end
    end

    assign serial_o = reg_q[STAGES-1];

endmodule

// File: rtl/clk_pulse_monitor.sv
// Measures high/low phases of an asynchronous clock in clk_i cycles,
// flags short phases as glitches and detects a stopped clock.
module clk_pulse_monitor
    import clk_monitor_pkg::*;
#(
    parameter int unsigned CNT_WIDTH     = 16,
    parameter int unsigned ERR_CNT_WIDTH = 8,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     en_i,
    input  logic                     clear_i,
    input  logic                     mon_clk_i,
    input  logic [CNT_WIDTH-1:0]     min_high_i,
    input  logic [CNT_WIDTH-1:0]     min_low_i,
    input  logic [CNT_WIDTH-1:0]     timeout_i,
    output logic [CNT_WIDTH-1:0]     high_width_o,
    output logic [CNT_WIDTH-1:0]     low_width_o,
    output logic                     meas_valid_o,
    output logic                     meas_high_o,
    output logic                     glitch_o,
    output logic                     glitch_sticky_o,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt_o,
    output logic                     stopped_o
);

    localparam logic [CNT_WIDTH-1:0]     CNT_ONE = 1;
    localparam logic [CNT_WIDTH-1:0]     CNT_MAX = '1;
    localparam logic [ERR_CNT_WIDTH-1:0] ERR_ONE = 1;
    localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX = '1;

    logic s;
    logic s_q;
    logic rise;
    logic fall;

    mon_state_e state_q, state_d;

    logic [CNT_WIDTH-1:0]     cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]     cnt_inc;
    logic [CNT_WIDTH-1:0]     hw_q, hw_d;
    logic [CNT_WIDTH-1:0]     lw_q, lw_d;
    logic                     mv_q, mv_d;
    logic                     mh_q, mh_d;
    logic                     gl_q, gl_d;
    logic                     st_q, st_d;
    logic                     sticky_q, sticky_d;
    logic [ERR_CNT_WIDTH-1:0] err_q, err_d;
    logic [ERR_CNT_WIDTH-1:0] err_base;
    logic                     timeout_hit;

    sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .serial_i (mon_clk_i),
        .serial_o (s)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s_q <= 1'b0;
        end else begin
            s_q <= s;
        end
    end

    assign rise = s & ~s_q;
    assign fall = ~s & s_q;

    assign cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
    assign timeout_hit = (timeout_i != '0) && (cnt_q >= timeout_i);

    // A detected edge always wins over a coincident timeout.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hw_d    = hw_q;
        lw_d    = lw_q;
        mv_d    = 1'b0;
        mh_d    = mh_q;
        gl_d    = 1'b0;
        st_d    = st_q;

        if (rise || fall) begin
            st_d = 1'b0;
        end

        if (!en_i) begin
            state_d = SYNCING;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                SYNCING: begin
                    if (rise) begin
                        state_d = HIGH;
                        cnt_d   = CNT_ONE;
                    end else if (fall) begin
                        state_d = LOW;
                        cnt_d   = CNT_ONE;
                    end
                end
                HIGH: begin
                    if (fall) begin
                        hw_d    = cnt_q;
                        mv_d    = 1'b1;
                        mh_d    = 1'b1;
                        gl_d    = (cnt_q < min_high_i);
                        state_d = LOW;
                        cnt_d   = CNT_ONE;
                    end else if (timeout_hit) begin
                        st_d    = 1'b1;
                        state_d = SYNCING;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                LOW: begin
                    if (rise) begin
                        lw_d    = cnt_q;
                        mv_d    = 1'b1;
                        mh_d    = 1'b0;
                        gl_d    = (cnt_q < min_low_i);
                        state_d = HIGH;
                        cnt_d   = CNT_ONE;
                    end else if (timeout_hit) begin
                        st_d    = 1'b1;
                        state_d = SYNCING;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = SYNCING;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Clear is applied before the increment of a coincident glitch.
    always_comb begin
        err_base = clear_i ? '0 : err_q;
        err_d    = err_base;
        if (gl_q && (err_base != ERR_MAX)) begin
            err_d = err_base + ERR_ONE;
        end
        sticky_d = gl_q | (sticky_q & ~clear_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= SYNCING;
            cnt_q    <= '0;
            hw_q     <= '0;
            lw_q     <= '0;
            mv_q     <= 1'b0;
            mh_q     <= 1'b0;
            gl_q     <= 1'b0;
            st_q     <= 1'b0;
            sticky_q <= 1'b0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hw_q     <= hw_d;
            lw_q     <= lw_d;
            mv_q     <= mv_d;
            mh_q     <= mh_d;
            gl_q     <= gl_d;
            st_q     <= st_d;
            sticky_q <= sticky_d;
            err_q    <= err_d;
        end
    end

    assign high_width_o    = hw_q;
    assign low_width_o     = lw_q;
    assign meas_valid_o    = mv_q;
    assign meas_high_o     = mh_q;
    assign glitch_o        = gl_q;
    assign glitch_sticky_o = sticky_q;
    assign err_cnt_o       = err_q;
    assign stopped_o       = st_q;

endmodule

// File: tb/tb_clk_pulse_monitor.sv
// Directed bench for clk_pulse_monitor: phase vectors plus
// hand-built timeout, saturation, clear and reset sequences.
module tb_clk_pulse_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic        clear = 1'b0;
    logic        mon = 1'b0;
    logic [15:0] minh = '0;
    logic [15:0] minl = '0;
    logic [15:0] tmo = '0;
    logic [15:0] hw, lw;
    logic        mv, mh, gl, sticky, stopped;
    logic [7:0]  err;

    logic [3:0]  minh4 = '0;
    logic [3:0]  minl4 = '0;
    logic [3:0]  tmo4 = '0;
    logic [3:0]  hw4, lw4;
    logic        mv4, mh4, gl4, sticky4, stopped4;
    logic [7:0]  err4;

    int checks = 0;
    int errors = 0;
    int gl_cnt = 0;
    int glh_cnt = 0;
    int meas_cnt = 0;

    typedef struct {
        int          h;
        int          l;
        logic [15:0] minh;
        logic [15:0] minl;
        int          ehw;
        int          elw;
        int          egl;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    clk_pulse_monitor dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .clear_i(clear),
        .mon_clk_i(mon), .min_high_i(minh), .min_low_i(minl),
        .timeout_i(tmo), .high_width_o(hw), .low_width_o(lw),
        .meas_valid_o(mv), .meas_high_o(mh), .glitch_o(gl),
        .glitch_sticky_o(sticky), .err_cnt_o(err),
        .stopped_o(stopped)
    );

    clk_pulse_monitor #(.CNT_WIDTH(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .en_i(en), .clear_i(clear),
        .mon_clk_i(mon), .min_high_i(minh4), .min_low_i(minl4),
        .timeout_i(tmo4), .high_width_o(hw4), .low_width_o(lw4),
        .meas_valid_o(mv4), .meas_high_o(mh4), .glitch_o(gl4),
        .glitch_sticky_o(sticky4), .err_cnt_o(err4),
        .stopped_o(stopped4)
    );

    always @(negedge clk) begin
        if (gl) gl_cnt <= gl_cnt + 1;
        if (gl && mh) glh_cnt <= glh_cnt + 1;
        if (mv) meas_cnt <= meas_cnt + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic phase(input logic lvl, input int n);
        mon = lvl;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int g0, m0;
        mon = 1'b0;
        do_reset();
        minh = v.minh;
        minl = v.minl;
        tmo = '0;
        g0 = gl_cnt;
        m0 = meas_cnt;
        phase(0, 4);
        repeat (3) begin
            phase(1, v.h);
            phase(0, v.l);
        end
        phase(1, v.h + 5);
        chk($sformatf("v%0d_high_width", idx), int'(hw), v.ehw);
        chk($sformatf("v%0d_low_width", idx), int'(lw), v.elw);
        chk($sformatf("v%0d_glitches", idx), gl_cnt - g0, v.egl);
        chk($sformatf("v%0d_err_cnt", idx), int'(err), v.egl);
        chk($sformatf("v%0d_sticky", idx), int'(sticky), (v.egl > 0) ? 1 : 0);
        chk($sformatf("v%0d_meas", idx), meas_cnt - m0, 6);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g0, gh0, m0;
        bit found;

        vecs[0] = '{5, 7, 16'd3, 16'd3, 5, 7, 0};
        vecs[1] = '{3, 3, 16'd3, 16'd3, 3, 3, 0};
        vecs[2] = '{2, 6, 16'd3, 16'd3, 2, 6, 3};
        vecs[3] = '{6, 2, 16'd3, 16'd3, 6, 2, 3};
        vecs[4] = '{1, 2, 16'd2, 16'd2, 1, 2, 3};
        vecs[5] = '{4, 9, 16'd4, 16'd10, 4, 9, 3};

        repeat (3) @(negedge clk);
        chk("rst_high_width", int'(hw), 0);
        chk("rst_low_width", int'(lw), 0);
        chk("rst_meas_valid", int'(mv), 0);
        chk("rst_glitch", int'(gl), 0);
        chk("rst_err_cnt", int'(err), 0);
        chk("rst_stopped", int'(stopped), 0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // single short high phase
        mon = 1'b0;
        do_reset();
        minh = 16'd3;
        minl = 16'd3;
        g0 = gl_cnt;
        gh0 = glh_cnt;
        phase(0, 5); phase(1, 5); phase(0, 5); phase(1, 2);
        phase(0, 5); phase(1, 5); phase(0, 5);
        chk("one_glitch_count", gl_cnt - g0, 1);
        chk("one_glitch_high", glh_cnt - gh0, 1);
        chk("one_glitch_err", int'(err), 1);
        chk("one_glitch_sticky", int'(sticky), 1);

        // disabled monitor ignores edges
        m0 = meas_cnt;
        en = 1'b0;
        phase(1, 3); phase(0, 3); phase(1, 3); phase(0, 3);
        chk("disabled_meas", meas_cnt - m0, 0);
        en = 1'b1;

        // stopped clock
        mon = 1'b0;
        do_reset();
        minh = '0;
        minl = '0;
        tmo = 16'd20;
        phase(0, 3);
        phase(1, 5);
        mon = 1'b0;
        repeat (19) @(negedge clk);
        chk("stop_early", int'(stopped), 0);
        repeat (5) @(negedge clk);
        chk("stop_set", int'(stopped), 1);
        chk("stop_low_width", int'(lw), 0);
        chk("stop_high_width", int'(hw), 5);
        m0 = meas_cnt;
        mon = 1'b1;
        repeat (4) @(negedge clk);
        chk("stop_cleared", int'(stopped), 0);
        chk("stop_no_meas", meas_cnt - m0, 0);
        chk("stop_low_kept", int'(lw), 0);
        repeat (2) @(negedge clk);
        phase(0, 4);
        chk("stop_next_high", int'(hw), 6);

        // counter saturation on the narrow instance
        mon = 1'b0;
        tmo = '0;
        do_reset();
        phase(0, 3); phase(1, 3); phase(0, 3); phase(1, 30); phase(0, 4);
        chk("sat_high_width4", int'(hw4), 15);
        chk("sat_low_width4", int'(lw4), 3);
        chk("sat_high_width16", int'(hw), 30);
        chk("sat_err4", int'(err4), 0);

        // clear coincident with a glitch
        mon = 1'b0;
        do_reset();
        minh = 16'd3;
        phase(0, 4);
        repeat (5) begin
            phase(1, 2);
            phase(0, 6);
        end
        chk("clr_err_before", int'(err), 5);
        phase(1, 2);
        mon = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (gl) begin
                found = 1'b1;
                break;
            end
        end
        chk("clr_wait_glitch", int'(found), 1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clr_coinc_err", int'(err), 1);
        chk("clr_coinc_sticky", int'(sticky), 1);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clr_only_err", int'(err), 0);
        chk("clr_only_sticky", int'(sticky), 0);

        // reset in the middle of a high phase
        minh = 16'd3;
        minl = 16'd3;
        phase(0, 3); phase(1, 5); phase(0, 5);
        mon = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mon = 1'b0;
        chk("midrst_high_width", int'(hw), 0);
        chk("midrst_low_width", int'(lw), 0);
        chk("midrst_err", int'(err), 0);
        chk("midrst_sticky", int'(sticky), 0);
        g0 = gl_cnt;
        @(negedge clk);
        phase(1, 8);
        phase(0, 6);
        chk("midrst_no_glitch", gl_cnt - g0, 0);
        chk("midrst_first_high", int'(hw), 8);
        chk("midrst_low_unmeasured", int'(lw), 0);
        phase(1, 5);
        chk("midrst_first_low", int'(lw), 6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_pulse_monitor.md
# clk_pulse_monitor

Synthesizable monitor that samples an asynchronous clock, e.g. the output of a glitch-free clock multiplexer, in the `clk_i` domain. It measures every high and low phase in `clk_i` cycles and flags phases shorter than programmable minimums as glitches. It also detects a stopped clock. It sits at the consuming end of clock-switching logic and provides on-chip, self-checking coverage of switch events.

## Interface
- `CNT_WIDTH`, default 16: width of the phase counters, thresholds and measured widths.
- `ERR_CNT_WIDTH`, default 8: width of the saturating glitch counter.
- `SYNC_STAGES`, default 2: synchronizer depth for `mon_clk_i`, minimum 2.
- `clk_i` in 1: sampling clock; must be faster than 2x the monitored clock frequency.
- `rst_i` in 1: reset, synchronous, active-high.
- `en_i` in 1: monitor enable; when 0, the FSM is held in SYNCING.
- `clear_i` in 1: single-cycle pulse that clears `glitch_sticky_o` and `err_cnt_o`.
- `mon_clk_i` in 1: monitored clock, asynchronous to `clk_i`.
- `min_high_i` in CNT_WIDTH: minimum legal high width, in cycles.
- `min_low_i` in CNT_WIDTH: minimum legal low width, in cycles.
- `timeout_i` in CNT_WIDTH: phase length at which the clock is declared stopped; 0 disables the check.
- `high_width_o` out CNT_WIDTH: width of the last completed high phase.
- `low_width_o` out CNT_WIDTH: width of the last completed low phase.
- `meas_valid_o` out 1: one-cycle pulse when a phase completes.
- `meas_high_o` out 1: qualifies `meas_valid_o`; 1 means a high phase completed, 0 means a low phase completed.
- `glitch_o` out 1: one-cycle pulse when a phase is shorter than its minimum.
- `glitch_sticky_o` out 1: set by `glitch_o`, cleared by `clear_i`.
- `err_cnt_o` out ERR_CNT_WIDTH: glitch count; saturates at all-ones.
- `stopped_o` out 1: level; timeout reached, cleared at the next detected edge.

## Operation
- Reset values: all outputs 0, synchronizer flops 0, FSM in SYNCING, counter 0.
- `mon_clk_i` passes through `SYNC_STAGES` flops, giving `s`, plus one delay flop, giving `s_q`.
  - `rise` = `s & ~s_q`; `fall` = `~s & s_q`.
- FSM states: SYNCING, HIGH, LOW.
  - SYNCING: the first phase after reset or enable is partial and is discarded, with no measurement and no check.
    - On `rise`: go to HIGH, counter := 1.
    - On `fall`: go to LOW, counter := 1.
  - HIGH: counter increments each cycle, saturating at all-ones.
    - On `fall`: `high_width_o` := counter; pulse `meas_valid_o` with `meas_high_o` = 1; if counter < `min_high_i`, pulse `glitch_o`. Then go to LOW with counter := 1.
  - LOW: mirror of HIGH, using `rise`, `low_width_o` and `min_low_i`.
  - Timeout, in HIGH or LOW: if `timeout_i` != 0 and counter >= `timeout_i`, set `stopped_o` and go to SYNCING. No glitch is reported and the widths are not updated.
  - `stopped_o` clears on the cycle any `rise` or `fall` is detected.
- `en_i` = 0: FSM forced to SYNCING and counter to 0. Registered outputs hold their values. The synchronizer keeps running.
- `glitch_o` increments `err_cnt_o` (saturating) and sets `glitch_sticky_o`.
- `clear_i` in the same cycle as `glitch_o`: the clear applies first, then the increment, giving `err_cnt_o` = 1 and `glitch_sticky_o` = 1.
- `rst_i` mid-phase: all state returns to reset values on the next edge. The in-flight phase is discarded.
- Thresholds are sampled at the moment of comparison. Changing them mid-phase is legal.

## Timing
- `clk_i` edges are numbered from k, the first edge that samples the new `mon_clk_i` level. Detection registers update at edge k + `SYNC_STAGES`.
- Width resolution is ±1 cycle because of synchronizer uncertainty. A phase of H sampled cycles reports H.
- `meas_valid_o` and `glitch_o` assert in the same cycle and last one cycle.
- `err_cnt_o` and `glitch_sticky_o` update one edge after `glitch_o` is computed, i.e. they are visible in the cycle after the `glitch_o` pulse.

## Structure
- Package `clk_monitor_pkg` holds the state enum `mon_state_e` (SYNCING, HIGH, LOW).
- Sub-module: the common-cells `sync` cell, instantiated with `STAGES` = `SYNC_STAGES`. The edge-detect flop, FSM and counters live in the top module.

## Test plan
- Steady clock, 5 cycles high / 7 cycles low, `min_high_i` = `min_low_i` = 3: `high_width_o` = 5 and `low_width_o` = 7 (±1 cycle) after the first full period, no `glitch_o`, `err_cnt_o` = 0.
- Inject one high phase of 2 cycles with `min_high_i` = 3: exactly one `glitch_o` pulse with `meas_high_o` = 1; `err_cnt_o` = 1; `glitch_sticky_o` = 1.
- Hold `mon_clk_i` low with `timeout_i` = 20: `stopped_o` rises about 20 cycles after the last `fall`. The next edge clears it. The first phase after the timeout is not measured.
- Set `CNT_WIDTH` = 4, `timeout_i` = 0, hold high for 30 cycles: `high_width_o` = 15, saturated, with no wrap.
- Pulse `clear_i` in the same cycle as `glitch_o`, with `err_cnt_o` = 5 beforehand: `err_cnt_o` = 1 and `glitch_sticky_o` = 1.
- Assert `rst_i` mid-high-phase, then release: all outputs are 0. The first partial phase after release is discarded, and a true 1-cycle phase inside it does not raise a glitch.
